// File: rtl/input_manager.sv
// input_manager: UART receive path for the CPU's READI/READF instructions.
// Deserialises 8N1 bytes from UART_RX into a circular byte queue and, on
// request, pops four bytes and presents them big-endian as one 32-bit word.
// Usable queue capacity is DEPTH-1 (one slot keeps full and empty distinct).
module input_manager #(
    parameter int CLK_PER_BIT = 868,
    parameter int DEPTH       = 512
) (
    input  logic                     CLK,
    input  logic                     INITIALIZE,
    input  logic                     UART_RX,
    input  logic                     read_req,
    output logic                     read_valid,
    output logic [31:0]              read_data,
    output logic [$clog2(DEPTH)-1:0] byte_count,
    output logic                     overrun,
    output logic                     framing_error
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(CLK_PER_BIT + 1);
    localparam logic [TW-1:0] HALF_BIT  = TW'(CLK_PER_BIT / 2);
    localparam logic [TW-1:0] LAST_TICK = TW'(CLK_PER_BIT - 1);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_t;

    typedef enum logic {
        AS_IDLE,
        AS_COLLECT
    } as_state_t;

    // ------------------------------------------------------------------
    // Line synchroniser and edge history
    // ------------------------------------------------------------------
    logic rx_meta;
    logic rx_sync;
    logic rx_prev;

    // Two-flop synchroniser; all three reset low so a line held low across
    // INITIALIZE never looks like a fresh falling edge.
    always_ff @(posedge CLK) begin
        if (INITIALIZE) begin
            rx_meta <= 1'b0;
            rx_sync <= 1'b0;
            rx_prev <= 1'b0;
        end else begin
            rx_meta <= UART_RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    rx_state_t     rx_state;
    logic [TW-1:0] bit_timer;
    logic [2:0]    bit_idx;
    logic [7:0]    rx_shift;
    logic          push_req;
    logic [7:0]    push_byte;

    // Bit-level deserialiser: half-bit start check, then one sample per bit
    // period. A completed byte is handed to the queue as a one-cycle push.
    always_ff @(posedge CLK) begin
        if (INITIALIZE) begin
            rx_state      <= RX_IDLE;
            bit_timer     <= '0;
            bit_idx       <= '0;
            rx_shift      <= '0;
            push_req      <= 1'b0;
            push_byte     <= '0;
            framing_error <= 1'b0;
        end else begin
            push_req      <= 1'b0;
            framing_error <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    bit_timer <= '0;
                    if (rx_prev && !rx_sync) begin
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (bit_timer == HALF_BIT) begin
                        bit_timer <= '0;
                        bit_idx   <= '0;
                        // Line back high by mid-start-bit: treat as a glitch.
                        rx_state  <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        bit_timer <= bit_timer + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (bit_timer == LAST_TICK) begin
                        bit_timer <= '0;
                        // LSB arrives first, so shift in from the top.
                        rx_shift  <= {rx_sync, rx_shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        bit_timer <= bit_timer + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (bit_timer == LAST_TICK) begin
                        bit_timer <= '0;
                        if (rx_sync) begin
                            push_req  <= 1'b1;
                            push_byte <= rx_shift;
                            rx_state  <= RX_IDLE;
                        end else begin
                            framing_error <= 1'b1;
                            rx_state      <= RX_WAIT_IDLE;
                        end
                    end else begin
                        bit_timer <= bit_timer + 1'b1;
                    end
                end
                RX_WAIT_IDLE: begin
                    // Don't hunt for a start bit until the line recovers.
                    if (rx_sync) begin
                        rx_state <= RX_IDLE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Circular byte queue
    // ------------------------------------------------------------------
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          q_full;
    logic          q_empty;
    logic          do_push;
    logic          do_pop;
    logic [7:0]    q_head;
    as_state_t     as_state;

    // Full is judged on registered pointers, i.e. before any same-cycle pop.
    assign q_full     = (AW'(wp + 1'b1) == rp);
    assign q_empty    = (wp == rp);
    assign do_push    = push_req && !q_full;
    assign do_pop     = (as_state == AS_COLLECT) && !q_empty;
    assign q_head     = mem[rp];
    assign byte_count = wp - rp;

    // Storage array; contents are don't-care after reset since pointers clear.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wp] <= push_byte;
        end
    end

    // Pointer update and sticky overrun on a dropped push.
    always_ff @(posedge CLK) begin
        if (INITIALIZE) begin
            wp      <= '0;
            rp      <= '0;
            overrun <= 1'b0;
        end else begin
            if (do_push) begin
                wp <= wp + 1'b1;
            end
            if (do_pop) begin
                rp <= rp + 1'b1;
            end
            if (push_req && q_full) begin
                overrun <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Word assembler
    // ------------------------------------------------------------------
    logic [1:0]  as_k;
    logic [23:0] word_buf;

    // Pops four bytes (stalling on empty), first byte ends in [31:24];
    // the word and its valid pulse register on the 4th pop.
    always_ff @(posedge CLK) begin
        if (INITIALIZE) begin
            as_state   <= AS_IDLE;
            as_k       <= '0;
            word_buf   <= '0;
            read_valid <= 1'b0;
            read_data  <= '0;
        end else begin
            read_valid <= 1'b0;
            case (as_state)
                AS_IDLE: begin
                    if (read_req) begin
                        as_state <= AS_COLLECT;
                        as_k     <= '0;
                    end
                end
                AS_COLLECT: begin
                    if (!q_empty) begin
                        word_buf <= {word_buf[15:0], q_head};
                        as_k     <= as_k + 2'd1;
                        if (as_k == 2'd3) begin
                            read_data  <= {word_buf, q_head};
                            read_valid <= 1'b1;
                            as_state   <= AS_IDLE;
                        end
                    end
                end
                default: as_state <= AS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_input_manager.sv
// Bench for input_manager (CLK_PER_BIT=16, DEPTH=8). A byte scoreboard is
// filled as frames are driven and drained when read_valid appears; a vector
// table covers queue fill/overrun/framing, hand sequences the rest.
module tb_input_manager;

    localparam int CPB   = 16;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          CLK = 1'b0;
    logic          INITIALIZE;
    logic          UART_RX;
    logic          read_req;
    logic          read_valid;
    logic [31:0]   read_data;
    logic [AW-1:0] byte_count;
    logic          overrun;
    logic          framing_error;

    always #5 CLK = ~CLK;

    input_manager #(.CLK_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .CLK          (CLK),
        .INITIALIZE   (INITIALIZE),
        .UART_RX      (UART_RX),
        .read_req     (read_req),
        .read_valid   (read_valid),
        .read_data    (read_data),
        .byte_count   (byte_count),
        .overrun      (overrun),
        .framing_error(framing_error)
    );

    int n_pass    = 0;
    int n_tot     = 0;
    int valid_cnt = 0;
    int fe_cnt    = 0;
    int pend      = 0;
    logic [7:0] mq[$];

    typedef struct {
        logic [7:0] data;
        logic       stop_ok;
        int         exp_cnt;
        logic       exp_ovr;
        int         exp_fe;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Scoreboard push happens as the frame starts, so a pending word that
    // completes inside this frame already finds its byte in the model.
    task automatic send_byte(input logic [7:0] d, input logic stop_ok);
        if (stop_ok && mq.size() < DEPTH - 1) mq.push_back(d);
        UART_RX = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            UART_RX = d[i];
            wait_cyc(CPB);
        end
        UART_RX = stop_ok;
        wait_cyc(CPB);
        UART_RX = 1'b1;
        wait_cyc(4);
    endtask

    task automatic issue_read(input logic counted);
        read_req = 1'b1;
        if (counted) pend++;
        wait_cyc(1);
        read_req = 1'b0;
    endtask

    task automatic do_reset(input logic rx_level);
        UART_RX    = rx_level;
        INITIALIZE = 1'b1;
        wait_cyc(1);
        INITIALIZE = 1'b0;
        mq.delete();
        pend = 0;
    endtask

    task automatic wait_valid(input int base, input int maxc, input string nm);
        int c;
        c = 0;
        while (valid_cnt == base && c < maxc) begin
            wait_cyc(1);
            c++;
        end
        chk(nm, 32'(valid_cnt > base), 32'd1);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_valid"}, 32'(read_valid), 32'd0);
        chk({tag, "_data"}, read_data, 32'd0);
        chk({tag, "_count"}, 32'(byte_count), 32'd0);
        chk({tag, "_overrun"}, 32'(overrun), 32'd0);
        chk({tag, "_fe"}, 32'(framing_error), 32'd0);
    endtask

    // Output monitor: counts pulses and scores each delivered word.
    always @(negedge CLK) begin
        logic [31:0] e;
        if (framing_error === 1'b1) fe_cnt++;
        if (read_valid === 1'b1) begin
            valid_cnt++;
            chk("valid_has_request", 32'(pend > 0), 32'd1);
            chk("model_has_4_bytes", 32'(mq.size() >= 4), 32'd1);
            if (pend > 0 && mq.size() >= 4) begin
                e = '0;
                for (int i = 0; i < 4; i++) e = {e[23:0], mq.pop_front()};
                pend--;
                chk("read_data_sb", read_data, e);
            end
        end
    end

    initial begin
        int base;
        int lat;
        int fe0;

        tbl[0] = '{8'h55, 1'b0, 0, 1'b0, 1};
        for (int i = 1; i <= 7; i++) tbl[i] = '{8'(8'hA0 + i), 1'b1, i, 1'b0, 0};
        tbl[8] = '{8'hA8, 1'b1, 7, 1'b1, 0};

        INITIALIZE = 1'b1;
        UART_RX    = 1'b1;
        read_req   = 1'b0;
        wait_cyc(3);
        INITIALIZE = 1'b0;
        chk_zero_outputs("reset");
        wait_cyc(4);

        // 1: four bytes queued, then a read with fixed latency
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'h78, 1'b1);
        chk("t1_count4", 32'(byte_count), 32'd4);
        base = valid_cnt;
        read_req = 1'b1;
        pend++;
        wait_cyc(1);
        read_req = 1'b0;
        lat = 1;
        while (read_valid !== 1'b1 && lat < 20) begin
            wait_cyc(1);
            lat++;
        end
        chk("t1_latency", lat, 32'd5);
        chk("t1_data", read_data, 32'h12345678);
        wait_cyc(2);
        chk("t1_count0", 32'(byte_count), 32'd0);
        chk("t1_valid_once", valid_cnt - base, 32'd1);
        wait_cyc(10);
        chk("t1_hold", read_data, 32'h12345678);

        // 2: read issued on an empty queue; extra request while pending
        base = valid_cnt;
        issue_read(1'b1);
        wait_cyc(20);
        issue_read(1'b0);
        send_byte(8'hDE, 1'b1);
        send_byte(8'hAD, 1'b1);
        send_byte(8'hBE, 1'b1);
        chk("t2_no_early_valid", valid_cnt - base, 32'd0);
        send_byte(8'hEF, 1'b1);
        wait_valid(base, 40, "t2_valid_arrives");
        chk("t2_data", read_data, 32'hDEADBEEF);
        wait_cyc(40);
        chk("t2_single_valid", valid_cnt - base, 32'd1);
        chk("t2_count0", 32'(byte_count), 32'd0);

        // 4a: short low glitch is rejected
        do_reset(1'b1);
        wait_cyc(4);
        fe0  = fe_cnt;
        base = valid_cnt;
        UART_RX = 1'b0;
        wait_cyc(4);
        UART_RX = 1'b1;
        wait_cyc(40);
        chk("t4_glitch_count", 32'(byte_count), 32'd0);
        chk("t4_glitch_fe", fe_cnt - fe0, 32'd0);

        // 4b + 3: bad stop bit, then fill past capacity
        for (int i = 0; i < 9; i++) begin
            fe0 = fe_cnt;
            send_byte(tbl[i].data, tbl[i].stop_ok);
            chk($sformatf("tbl%0d_count", i), 32'(byte_count), tbl[i].exp_cnt);
            chk($sformatf("tbl%0d_overrun", i), 32'(overrun), 32'(tbl[i].exp_ovr));
            chk($sformatf("tbl%0d_fe", i), fe_cnt - fe0, tbl[i].exp_fe);
        end

        base = valid_cnt;
        issue_read(1'b1);
        wait_valid(base, 20, "t3_valid1");
        chk("t3_word1", read_data, 32'hA1A2A3A4);
        chk("t3_count3", 32'(byte_count), 32'd3);
        base = valid_cnt;
        issue_read(1'b1);
        wait_cyc(30);
        chk("t3_stall", valid_cnt - base, 32'd0);
        chk("t3_count0", 32'(byte_count), 32'd0);
        send_byte(8'hB0, 1'b1);
        wait_valid(base, 20, "t3_valid2");
        chk("t3_word2_wrap", read_data, 32'hA5A6A7B0);
        chk("t3_overrun_sticky", 32'(overrun), 32'd1);

        // 6: reset mid-word and mid-byte
        send_byte(8'hC1, 1'b1);
        send_byte(8'hC2, 1'b1);
        issue_read(1'b1);
        wait_cyc(10);
        chk("t6_popped", 32'(byte_count), 32'd0);
        UART_RX = 1'b0;
        wait_cyc(CPB);
        UART_RX = 1'b1;
        wait_cyc(CPB);
        UART_RX = 1'b0;
        wait_cyc(CPB / 2);
        do_reset(1'b0);
        chk_zero_outputs("t6_reset");
        fe0  = fe_cnt;
        base = valid_cnt;
        UART_RX = 1'b1;
        wait_cyc(200);
        chk("t6_byte_discarded", 32'(byte_count), 32'd0);
        chk("t6_no_fe", fe_cnt - fe0, 32'd0);
        chk("t6_no_valid", valid_cnt - base, 32'd0);
        send_byte(8'h0F, 1'b1);
        send_byte(8'h1E, 1'b1);
        send_byte(8'h2D, 1'b1);
        send_byte(8'h3C, 1'b1);
        base = valid_cnt;
        issue_read(1'b1);
        wait_valid(base, 20, "t6_valid");
        chk("t6_data", read_data, 32'h0F1E2D3C);

        // 5: line held low through and after reset
        fe0 = fe_cnt;
        do_reset(1'b0);
        wait_cyc(200);
        chk("t5_no_fe", fe_cnt - fe0, 32'd0);
        chk("t5_count0", 32'(byte_count), 32'd0);
        UART_RX = 1'b1;
        wait_cyc(20);
        send_byte(8'h3C, 1'b1);
        chk("t5_count1", 32'(byte_count), 32'd1);

        chk("pending_drained", pend, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/input_manager.md
Name: input_manager

Overview:
- UART input path feeding the CPU's READI/READF instructions.
- Deserialises 8N1 bytes from UART_RX and buffers them in a circular byte queue.
- On CPU request, assembles the next four queued bytes big-endian into one 32-bit word.
- Mirror of output_manager: output_manager drains the CPU's send queue onto UART_TX; this block fills a receive queue from UART_RX.

Parameters:
- CLK_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200).
- DEPTH, 512, byte queue entries (power of two); usable capacity is DEPTH-1.

Ports:
- CLK  in  1  system clock
- INITIALIZE  in  1  synchronous active-high reset
- UART_RX  in  1  serial input, idle high, asynchronous to CLK
- read_req  in  1  one-cycle pulse: request the next 32-bit word
- read_valid  out  1  one-cycle pulse: read_data holds the requested word
- read_data  out  32  assembled word; first received byte in [31:24]
- byte_count  out  $clog2(DEPTH)  bytes currently queued
- overrun  out  1  sticky: a byte was dropped because the queue was full
- framing_error  out  1  one-cycle pulse: stop bit sampled low

Behaviour:
- Reset: one clock, synchronous, active-high. While INITIALIZE is high at a CLK edge:
  - all outputs go to 0; queue pointers to 0; pending request cleared;
  - RX FSM to IDLE; an in-flight byte is discarded;
  - previous-sample register set to 0, so a line held low through reset is not taken as a start bit.
- Synchroniser: UART_RX passes through 2 flops before any use.
- RX FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE -> START: previous sample 1 and current sample 0; clear bit timer.
  - START: at timer = CLK_PER_BIT/2, if line low -> DATA (timer reset, bit index 0); if high -> IDLE (glitch rejected).
  - DATA: sample every CLK_PER_BIT cycles, LSB first, 8 bits; after bit 7 -> STOP.
  - STOP: sample after CLK_PER_BIT.
    - High: push byte, -> IDLE.
    - Low: pulse framing_error, drop byte, -> WAIT_IDLE.
  - WAIT_IDLE -> IDLE once the line samples high.
- Queue: write pointer wp, read pointer rp, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - Empty when wp == rp; full when wp+1 == rp.
  - byte_count = wp - rp (modulo).
  - A push while full (full evaluated before any same-cycle pop) is dropped and sets overrun, which stays high until INITIALIZE.
  - Simultaneous push and pop when not full: both take effect; byte_count unchanged.
- Word assembler states: IDLE, COLLECT(k = 0..3).
  - read_req in IDLE -> COLLECT(0). read_req in any other state is ignored (one request outstanding).
  - COLLECT(k): each cycle the queue is non-empty, pop one byte into bits [31-8k:24-8k] and advance k. Empty queue stalls without a timeout.
  - After the 4th pop, the next cycle: read_data updates, read_valid = 1 for exactly one cycle, -> IDLE.
  - Latency with at least 4 bytes queued: read_req at cycle N gives pops at N+1..N+4 and read_valid at N+5.
  - A byte pushed in the same cycle the queue was empty is visible to pop the following cycle.
  - read_data holds its value until the next read_valid.
- Reset mid-word: already-popped bytes are lost; the CPU must re-issue read_req.

Test Plan (CLK_PER_BIT=16, DEPTH=8):
1. Serialise bytes 0x12,0x34,0x56,0x78, then pulse read_req -> read_valid 5 cycles after read_req, read_data=0x12345678, byte_count back to 0.
2. Pulse read_req with the queue empty, then send 0xDE,0xAD,0xBE,0xEF -> read_valid only after the 4th stop bit plus pop latency, data=0xDEADBEEF; a second read_req while pending produces no extra read_valid.
3. Send 8 bytes with no reads -> byte_count saturates at 7, overrun=1 after the 8th byte; subsequent reads return bytes 1..7 in order, with wrap-around correct across the pointer boundary.
4. Drive a 4-cycle low glitch on UART_RX -> no push, byte_count stays 0; send 0x55 with the stop bit forced low -> framing_error single pulse, no push, byte not queued.
5. Hold UART_RX low through and after INITIALIZE -> no start detected until the line goes high then low again.
6. Assert INITIALIZE mid-byte and mid-word -> all outputs 0, overrun cleared; a following clean 4-byte transfer reads correctly.
